// File: rtl/fft_pkg.sv
// Shared constants, bin word layout and reader FSM states for the FFT bar display.
package fft_pkg;

    localparam int N_BINS    = 64;
    localparam int BAR_W     = 10;
    localparam int H_ACTIVE  = 640;
    localparam int V_ACTIVE  = 480;
    localparam int MAG_SHIFT = 6;
    localparam int MAG_W     = 9;

    typedef struct packed {
        logic signed [15:0] re;
        logic signed [15:0] im;
    } cplx_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        DRAIN   = 2'd2,
        WAIT_VB = 2'd3
    } state_t;

endpackage

// File: rtl/fft_bin_reader_mag_approx.sv
// L1 magnitude approximation of one complex bin, scaled and clipped to a bar height.
module mag_approx #(
    parameter int MAG_SHIFT = fft_pkg::MAG_SHIFT
) (
    input  logic signed [15:0] i_re,
    input  logic signed [15:0] i_im,
    output logic [8:0]         o_mag
);
    import fft_pkg::*;

    logic signed [17:0] w_re;
    logic signed [17:0] w_im;
    logic signed [17:0] w_abs_re;
    logic signed [17:0] w_abs_im;
    logic [17:0]        w_sum;
    logic [17:0]        w_shf;

    function automatic logic [8:0] sat_height(input logic [17:0] v);
        if (v > 18'(V_ACTIVE))
            return 9'(V_ACTIVE);
        return v[8:0];
    endfunction

    // Two guard bits keep |-32768| + |-32768| representable.
    assign w_re     = {{2{i_re[15]}}, i_re};
    assign w_im     = {{2{i_im[15]}}, i_im};
    assign w_abs_re = w_re[17] ? -w_re : w_re;
    assign w_abs_im = w_im[17] ? -w_im : w_im;
    assign w_sum    = unsigned'(w_abs_re + w_abs_im);
    assign w_shf    = w_sum >> MAG_SHIFT;
    assign o_mag    = sat_height(w_shf);

endmodule

// File: rtl/fft_bin_reader.sv
// Fetches one FFT frame into a shadow buffer, swaps it to the display buffer in
// vblank, and renders the display buffer as a 640x480 bar chart.
module fft_bin_reader #(
    parameter int N_BINS    = fft_pkg::N_BINS,
    parameter int BAR_W     = fft_pkg::BAR_W,
    parameter int MAG_SHIFT = fft_pkg::MAG_SHIFT
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      frame_done,
    output logic                      mem_rd_en,
    output logic [$clog2(N_BINS)-1:0] mem_addr,
    input  logic [31:0]               mem_rdata,
    output logic                      busy,
    input  logic [9:0]                pix_x,
    input  logic [9:0]                pix_y,
    input  logic                      pix_active,
    input  logic                      vblank,
    output logic [3:0]                r,
    output logic [3:0]                g,
    output logic [3:0]                b
);
    import fft_pkg::*;

    localparam int              AW   = $clog2(N_BINS);
    localparam logic [AW-1:0]   LAST = AW'(N_BINS - 1);
    localparam logic [9:0]      BW   = 10'(BAR_W);

    state_t          r_state;
    state_t          w_next;
    logic [AW-1:0]   r_addr;
    logic            r_cap_vld;
    logic [AW-1:0]   r_cap_addr;
    logic [8:0]      r_shadow [N_BINS];
    logic [8:0]      r_disp   [N_BINS];
    logic            w_swap;
    cplx_t           w_word;
    logic [8:0]      w_mag;

    logic [9:0]      w_bin;
    logic [9:0]      w_col;
    logic [8:0]      w_h;
    logic [9:0]      w_top;
    logic            w_lit;
    logic            w_red;
    logic [3:0]      r_red;
    logic [3:0]      r_grn;
    logic [3:0]      r_blu;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        mem_rd_en = 1'b0;
        busy      = 1'b1;
        w_swap    = 1'b0;
        case (r_state)
            IDLE: begin
                busy = 1'b0;
                if (frame_done)
                    w_next = FETCH;
            end
            FETCH: begin
                mem_rd_en = 1'b1;
                if (r_addr == LAST)
                    w_next = DRAIN;
            end
            DRAIN: begin
                w_next = WAIT_VB;
            end
            WAIT_VB: begin
                if (vblank) begin
                    w_swap = 1'b1;
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    assign mem_addr = r_addr;

    // Read data lags the strobe by one cycle, so address travels with a valid flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr     <= '0;
            r_cap_vld  <= 1'b0;
            r_cap_addr <= '0;
        end else begin
            r_addr     <= (r_state == FETCH) ? r_addr + 1'b1 : '0;
            r_cap_vld  <= mem_rd_en;
            r_cap_addr <= r_addr;
        end
    end

    assign w_word = mem_rdata;

    mag_approx #(
        .MAG_SHIFT (MAG_SHIFT)
    ) u_mag (
        .i_re  (w_word.re),
        .i_im  (w_word.im),
        .o_mag (w_mag)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_BINS; i++) begin
                r_shadow[i] <= '0;
                r_disp[i]   <= '0;
            end
        end else begin
            if (r_cap_vld)
                r_shadow[r_cap_addr] <= w_mag;
            if (w_swap)
                r_disp <= r_shadow;
        end
    end

    // Pixel path: bar lookup and lighting decision, one register to the outputs.
    assign w_bin = pix_x / BW;
    assign w_col = pix_x % BW;
    assign w_h   = (w_bin < 10'(N_BINS)) ? r_disp[w_bin[AW-1:0]] : 9'd0;
    assign w_top = 10'(V_ACTIVE) - {1'b0, w_h};
    assign w_lit = pix_active && (pix_y >= w_top) && (pix_y < 10'(V_ACTIVE))
                   && (w_col != BW - 10'd1);
    assign w_red = pix_y < (w_top + 10'd8);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_red <= 4'h0;
            r_grn <= 4'h0;
            r_blu <= 4'h0;
        end else begin
            r_red <= (w_lit && w_red) ? 4'hF : 4'h0;
            r_grn <= w_lit ? 4'hF : 4'h0;
            r_blu <= 4'h0;
        end
    end

    assign r = r_red;
    assign g = r_grn;
    assign b = r_blu;

endmodule

// File: tb/tb_fft_bin_reader.sv
// Directed bench for fft_bin_reader: fetch sequencing, swap timing, bar rendering, reset.
module tb_fft_bin_reader;

    logic        clk;
    logic        rst_n;
    logic        frame_done;
    logic        mem_rd_en;
    logic [5:0]  mem_addr;
    logic [31:0] mem_rdata;
    logic        busy;
    logic [9:0]  pix_x;
    logic [9:0]  pix_y;
    logic        pix_active;
    logic        vblank;
    logic [3:0]  r;
    logic [3:0]  g;
    logic [3:0]  b;

    logic [31:0] tb_mem [64];
    int          checks;
    int          failures;

    typedef struct packed {
        logic [9:0]  x;
        logic [9:0]  y;
        logic        act;
        logic [11:0] rgb;
    } pv_t;

    fft_bin_reader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame_done (frame_done),
        .mem_rd_en  (mem_rd_en),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .busy       (busy),
        .pix_x      (pix_x),
        .pix_y      (pix_y),
        .pix_active (pix_active),
        .vblank     (vblank),
        .r          (r),
        .g          (g),
        .b          (b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk)
        mem_rdata <= mem_rd_en ? tb_mem[mem_addr] : 32'h0;

    task automatic apply_pix(input logic [9:0] x, input logic [9:0] y, input logic act);
        @(negedge clk);
        pix_x      = x;
        pix_y      = y;
        pix_active = act;
        @(negedge clk);
    endtask

    task automatic pulse_frame_done();
        @(negedge clk);
        frame_done = 1'b1;
        @(negedge clk);
        frame_done = 1'b0;
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        pix_x      = 10'd0;
        pix_y      = 10'd479;
        pix_active = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (mem_rd_en !== 1'b0) begin failures++; $display("FAIL reset_rd_en got=%b exp=0", mem_rd_en); end
        checks++; if (mem_addr !== 6'd0) begin failures++; $display("FAIL reset_addr got=%0d exp=0", mem_addr); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if ({r, g, b} !== 12'h000) begin failures++; $display("FAIL reset_rgb got=%h exp=000", {r, g, b}); end
        rst_n = 1'b1;
        apply_pix(10'd0, 10'd479, 1'b1);
        checks++; if ({r, g, b} !== 12'h000) begin failures++; $display("FAIL reset_disp_clear got=%h exp=000", {r, g, b}); end
    endtask

    task automatic test_fetch();
        int n;
        int bad_addr;
        vblank = 1'b0;
        n = 0;
        bad_addr = 0;
        pulse_frame_done();
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL fetch_busy_rise got=%b exp=1", busy); end
        for (int i = 0; i < 200; i++) begin
            if (mem_rd_en === 1'b1) begin
                if (mem_addr !== 6'(n)) bad_addr++;
                n++;
            end else if (n > 0) begin
                break;
            end
            @(negedge clk);
        end
        checks++; if (n != 64) begin failures++; $display("FAIL fetch_read_count got=%0d exp=64", n); end
        checks++; if (bad_addr != 0) begin failures++; $display("FAIL fetch_addr_seq bad=%0d exp=0", bad_addr); end
        repeat (5) @(negedge clk);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL fetch_busy_waitvb got=%b exp=1", busy); end
        apply_pix(10'd55, 10'd479, 1'b1);
        checks++; if ({r, g, b} !== 12'h000) begin failures++; $display("FAIL fetch_no_early_swap got=%h exp=000", {r, g, b}); end
        vblank = 1'b1;
        for (int i = 0; i < 20 && busy === 1'b1; i++) @(negedge clk);
        vblank = 1'b0;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL fetch_busy_fall got=%b exp=0", busy); end
    endtask

    task automatic test_bar();
        pv_t v [$];
        v = '{
            '{10'd50, 10'd380, 1'b1, 12'hFF0},
            '{10'd50, 10'd379, 1'b1, 12'h000},
            '{10'd55, 10'd387, 1'b1, 12'hFF0},
            '{10'd55, 10'd388, 1'b1, 12'h0F0},
            '{10'd58, 10'd479, 1'b1, 12'h0F0},
            '{10'd59, 10'd400, 1'b1, 12'h000},
            '{10'd49, 10'd479, 1'b1, 12'h000},
            '{10'd52, 10'd450, 1'b0, 12'h000}
        };
        foreach (v[i]) begin
            apply_pix(v[i].x, v[i].y, v[i].act);
            checks++;
            if ({r, g, b} !== v[i].rgb) begin
                failures++;
                $display("FAIL bar100_x%0d_y%0d got=%h exp=%h", v[i].x, v[i].y, {r, g, b}, v[i].rgb);
            end
        end
    endtask

    task automatic test_saturate();
        pv_t v [$];
        v = '{
            '{10'd0, 10'd0,   1'b1, 12'hFF0},
            '{10'd3, 10'd7,   1'b1, 12'hFF0},
            '{10'd3, 10'd8,   1'b1, 12'h0F0},
            '{10'd8, 10'd479, 1'b1, 12'h0F0},
            '{10'd9, 10'd0,   1'b1, 12'h000}
        };
        foreach (v[i]) begin
            apply_pix(v[i].x, v[i].y, v[i].act);
            checks++;
            if ({r, g, b} !== v[i].rgb) begin
                failures++;
                $display("FAIL bar480_x%0d_y%0d got=%h exp=%h", v[i].x, v[i].y, {r, g, b}, v[i].rgb);
            end
        end
    endtask

    task automatic test_ignore_retrigger();
        int reads;
        int busy_cyc;
        int falls;
        logic prev_busy;
        tb_mem[5] = 32'h0640_0640;
        vblank = 1'b1;
        reads = 0;
        busy_cyc = 0;
        falls = 0;
        prev_busy = 1'b0;
        @(negedge clk);
        frame_done = 1'b1;
        @(negedge clk);
        frame_done = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (mem_rd_en === 1'b1) reads++;
            if (busy === 1'b1) busy_cyc++;
            if (prev_busy === 1'b1 && busy === 1'b0) falls++;
            prev_busy = busy;
            frame_done = (i == 10);
            @(negedge clk);
        end
        vblank = 1'b0;
        checks++; if (reads != 64) begin failures++; $display("FAIL ignore_reads got=%0d exp=64", reads); end
        checks++; if (falls != 1) begin failures++; $display("FAIL ignore_busy_falls got=%0d exp=1", falls); end
        checks++; if (busy_cyc != 66) begin failures++; $display("FAIL ignore_busy_cycles got=%0d exp=66", busy_cyc); end
        apply_pix(10'd50, 10'd429, 1'b1);
        checks++; if ({r, g, b} !== 12'h000) begin failures++; $display("FAIL bar50_y429 got=%h exp=000", {r, g, b}); end
        apply_pix(10'd50, 10'd430, 1'b1);
        checks++; if ({r, g, b} !== 12'hFF0) begin failures++; $display("FAIL bar50_y430 got=%h exp=FF0", {r, g, b}); end
    endtask

    task automatic test_vblank_hold();
        tb_mem[5] = 32'h0C80_F380;
        vblank = 1'b0;
        pulse_frame_done();
        repeat (70) @(negedge clk);
        repeat (1000) @(negedge clk);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL hold_busy got=%b exp=1", busy); end
        apply_pix(10'd50, 10'd429, 1'b1);
        checks++; if ({r, g, b} !== 12'h000) begin failures++; $display("FAIL hold_display_kept got=%h exp=000", {r, g, b}); end
        vblank = 1'b1;
        @(negedge clk);
        vblank = 1'b0;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL hold_busy_after_swap got=%b exp=0", busy); end
        apply_pix(10'd50, 10'd380, 1'b1);
        checks++; if ({r, g, b} !== 12'hFF0) begin failures++; $display("FAIL hold_swapped got=%h exp=FF0", {r, g, b}); end
    endtask

    task automatic test_reset_mid();
        int n;
        int bad_addr;
        logic found;
        vblank = 1'b0;
        apply_pix(10'd50, 10'd400, 1'b1);
        checks++; if ({r, g, b} !== 12'h0F0) begin failures++; $display("FAIL mid_pre_rgb got=%h exp=0F0", {r, g, b}); end
        pulse_frame_done();
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (mem_rd_en === 1'b1 && mem_addr === 6'd30) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checks++; if (!found) begin failures++; $display("FAIL mid_reach_addr30 got=0 exp=1"); end
        rst_n = 1'b0;
        #1;
        checks++; if (mem_rd_en !== 1'b0) begin failures++; $display("FAIL mid_rd_en got=%b exp=0", mem_rd_en); end
        checks++; if (mem_addr !== 6'd0) begin failures++; $display("FAIL mid_addr got=%0d exp=0", mem_addr); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mid_busy got=%b exp=0", busy); end
        checks++; if ({r, g, b} !== 12'h000) begin failures++; $display("FAIL mid_rgb got=%h exp=000", {r, g, b}); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if ({r, g, b} !== 12'h000) begin failures++; $display("FAIL mid_disp_cleared got=%h exp=000", {r, g, b}); end
        n = 0;
        bad_addr = 0;
        pulse_frame_done();
        for (int i = 0; i < 200; i++) begin
            if (mem_rd_en === 1'b1) begin
                if (mem_addr !== 6'(n)) bad_addr++;
                n++;
            end else if (n > 0) begin
                break;
            end
            @(negedge clk);
        end
        checks++; if (n != 64) begin failures++; $display("FAIL mid_restart_count got=%0d exp=64", n); end
        checks++; if (bad_addr != 0) begin failures++; $display("FAIL mid_restart_addr bad=%0d exp=0", bad_addr); end
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        frame_done = 1'b0;
        vblank     = 1'b0;
        pix_x      = 10'd0;
        pix_y      = 10'd0;
        pix_active = 1'b0;
        rst_n      = 1'b0;
        for (int i = 0; i < 64; i++) tb_mem[i] = 32'h0;
        tb_mem[0] = 32'h8000_8000;
        tb_mem[5] = 32'h0C80_F380;

        test_reset();
        test_fetch();
        test_bar();
        test_saturate();
        test_ignore_retrigger();
        test_vblank_hold();
        test_reset_mid();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
